// File: rtl/seq_bin_to_bcd.sv
// Sequential double-dabble converter: unsigned binary magnitude to packed BCD,
// one input bit per clock, with a start/busy/done handshake.
module seq_bin_to_bcd #(
  parameter int BIN_W  = 15,
  parameter int DIGITS = 5
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  function automatic longint pow10(input int n);
    longint r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

  localparam longint MAX_BIN = (64'd1 << BIN_W) - 64'd1;
  localparam longint MAX_BCD = pow10(DIGITS) - 64'd1;

  if (MAX_BIN > MAX_BCD) begin : g_range_check
    $fatal(1, "seq_bin_to_bcd: DIGITS too small for BIN_W");
  end

  // Add-3 correction for every digit that is 5 or more; no carry between digits.
  function automatic logic [ACC_W-1:0] dabble_adjust(input logic [ACC_W-1:0] a);
    logic [ACC_W-1:0] r;
    r = a;
    for (int d = 0; d < DIGITS; d++) begin
      if (a[4*d +: 4] >= 4'd5) begin
        r[4*d +: 4] = a[4*d +: 4] + 4'd3;
      end else begin
        r[4*d +: 4] = a[4*d +: 4];
      end
    end
    return r;
  endfunction

  typedef enum logic [0:0] {IDLE = 1'b0, CONV = 1'b1} state_t;

  state_t                   state_r, state_next_s;
  logic [BIN_W-1:0]         shift_r;
  logic [ACC_W-1:0]         acc_r;
  logic [CNT_W-1:0]         count_r;
  logic [ACC_W-1:0]         bcd_r;
  logic                     busy_r, done_r;
  logic                     busy_next_s, done_next_s;
  logic                     last_step_s;
  logic [ACC_W+BIN_W-1:0]   step_s;

  assign last_step_s = (count_r == CNT_W'(1));
  assign step_s      = {dabble_adjust(acc_r), shift_r} << 1'b1;

  // State register.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = CONV;
        end else begin
          state_next_s = IDLE;
        end
      end
      CONV: begin
        if (last_step_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = CONV;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Output decode; busy and done are registered from these.
  always_comb begin
    busy_next_s = 1'b0;
    done_next_s = 1'b0;
    case (state_r)
      IDLE: begin
        busy_next_s = start;
        done_next_s = 1'b0;
      end
      CONV: begin
        busy_next_s = !last_step_s;
        done_next_s = last_step_s;
      end
      default: begin
        busy_next_s = 1'b0;
        done_next_s = 1'b0;
      end
    endcase
  end

  // Datapath and registered handshake outputs.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      shift_r <= {BIN_W{1'b0}};
      acc_r   <= {ACC_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
      bcd_r   <= {ACC_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      busy_r <= busy_next_s;
      done_r <= done_next_s;
      case (state_r)
        IDLE: begin
          if (start) begin
            shift_r <= bin_in;
            acc_r   <= {ACC_W{1'b0}};
            count_r <= CNT_W'(BIN_W);
          end
        end
        CONV: begin
          acc_r   <= step_s[ACC_W+BIN_W-1:BIN_W];
          shift_r <= step_s[BIN_W-1:0];
          count_r <= count_r - CNT_W'(1);
          // bcd only ever sees the completed result.
          if (last_step_s) begin
            bcd_r <= step_s[ACC_W+BIN_W-1:BIN_W];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign bcd  = bcd_r;

endmodule

// File: tb/tb_seq_bin_to_bcd.sv
// Scoreboard bench for seq_bin_to_bcd: stimulus pushes expected BCD, a monitor
// pops and compares on every done pulse.
module tb_seq_bin_to_bcd;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic        start;
  logic [14:0] bin_in;
  logic        busy;
  logic        done;
  logic [19:0] bcd;

  int          checks   = 0;
  int          errors   = 0;
  int          done_cnt = 0;
  logic [19:0] exp_q[$];

  always #5 sys_clk = ~sys_clk;

  seq_bin_to_bcd #(.BIN_W(15), .DIGITS(5)) dut (
    .sys_clk(sys_clk),
    .rst    (rst),
    .start  (start),
    .bin_in (bin_in),
    .busy   (busy),
    .done   (done),
    .bcd    (bcd)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge sys_clk) begin
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        check("bcd_result", {12'd0, bcd}, {12'd0, exp_q.pop_front()});
      end
    end
  end

  // Issue a start at the current negedge; optionally inject a second start
  // at cycle inj_cyc. Returns edges from accept to done and busy cycles.
  task automatic conv(input logic [14:0] v, input logic [19:0] e,
                      input int inj_cyc, input logic [14:0] inj_val,
                      output int lat, output int busy_cnt);
    start    = 1'b1;
    bin_in   = v;
    exp_q.push_back(e);
    lat      = -1;
    busy_cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge sys_clk);
      start = 1'b0;
      if (i == inj_cyc) begin
        start  = 1'b1;
        bin_in = inj_val;
      end
      if (done) begin
        lat = i - 1;
        break;
      end
      if (busy) busy_cnt++;
    end
    if (lat < 0) check("done_timeout", 32'd1, 32'd0);
  endtask

  int lat, bc, n0;

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    bin_in = 15'd0;
    repeat (3) @(negedge sys_clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_bcd",  {12'd0, bcd},  32'd0);
    rst = 1'b0;
    @(negedge sys_clk);

    // T1: zero
    conv(15'd0, 20'h00000, 0, 15'd0, lat, bc);
    check("t1_latency", lat, 32'd15);
    check("t1_busy_cycles", bc, 32'd15);
    @(negedge sys_clk);
    check("t1_done_pulse", {31'd0, done}, 32'd0);
    check("t1_busy_idle",  {31'd0, busy}, 32'd0);

    // T2: 12345
    repeat (2) @(negedge sys_clk);
    conv(15'd12345, 20'h12345, 0, 15'd0, lat, bc);
    check("t2_latency", lat, 32'd15);
    check("t2_busy_cycles", bc, 32'd15);
    @(negedge sys_clk);
    check("t2_done_pulse", {31'd0, done}, 32'd0);
    check("t2_bcd_hold", {12'd0, bcd}, 32'h12345);

    // T4: start while busy ignored
    @(posedge sys_clk);
    n0 = done_cnt;
    @(negedge sys_clk);
    conv(15'd100, 20'h00100, 5, 15'd777, lat, bc);
    check("t4_latency", lat, 32'd15);
    repeat (20) @(negedge sys_clk);
    @(posedge sys_clk);
    check("t4_done_count", done_cnt - n0, 32'd1);
    check("t4_bcd_hold", {12'd0, bcd}, 32'h00100);

    // T5: reset mid-conversion
    @(negedge sys_clk);
    start  = 1'b1;
    bin_in = 15'd4321;
    for (int i = 1; i <= 7; i++) begin
      @(negedge sys_clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge sys_clk);
    rst = 1'b0;
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_done", {31'd0, done}, 32'd0);
    check("t5_bcd",  {12'd0, bcd},  32'd0);
    @(posedge sys_clk);
    n0 = done_cnt;
    repeat (30) @(negedge sys_clk);
    @(posedge sys_clk);
    check("t5_no_done", done_cnt - n0, 32'd0);
    @(negedge sys_clk);
    conv(15'd56, 20'h00056, 0, 15'd0, lat, bc);
    check("t5_latency", lat, 32'd15);

    // T6: back-to-back 9999 then 10000 in the done cycle
    repeat (2) @(negedge sys_clk);
    conv(15'd9999, 20'h09999, 0, 15'd0, lat, bc);
    conv(15'd10000, 20'h10000, 0, 15'd0, lat, bc);
    check("t6_done_gap", lat + 1, 32'd16);

    // T3: maximum
    conv(15'd32767, 20'h32767, 0, 15'd0, lat, bc);
    check("t3_latency", lat, 32'd15);
    @(negedge sys_clk);
    check("t3_bcd_hold", {12'd0, bcd}, 32'h32767);

    repeat (3) @(negedge sys_clk);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
